// File: rtl/mips_defs_pkg.sv
// Shared MIPS-subset encodings: opcodes, functs, ifu next-PC select,
// ALU/extender controls, controller states and decoded instruction classes.
package mips_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BEQ  = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_LUI  = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HI16 = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5,
    S_BR     = 3'd6,
    S_JMP    = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_ILL
  } ins_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier for the multi-cycle controller.
module mc_decode
  import mips_defs_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output ins_class_t  cls,
  output logic        illegal
);

  always_comb begin
    cls = C_ILL;
    unique case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU)      cls = C_ADDU;
        else if (funct == FN_SUBU) cls = C_SUBU;
      end
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_J:    cls = C_J;
      default: cls = C_ILL;
    endcase
  end

  assign illegal = (cls == C_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: IR, FETCH..WB sequencing, datapath controls
// and retired-instruction counter.
module mc_ctrl
  import mips_defs_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins,
  input  logic             zero,
  output logic             pc_wr,
  output logic [1:0]       npc_sel,
  output logic             ir_wr,
  output logic             reg_dst,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             mem_wr,
  output logic             mem_to_reg,
  output logic             reg_wr,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t      cur, nxt;
  logic [31:0] ir;
  ins_class_t  cls;
  logic        dec_ill;
  logic        ret_inc;
  logic        hold_alu;
  logic        unused_ir;

  mc_decode u_decode (
    .op      (ir[31:26]),
    .funct   (ir[5:0]),
    .cls     (cls),
    .illegal (dec_ill)
  );

  assign unused_ir = ^ir[25:6];
  assign state     = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur     <= S_FETCH;
      ir      <= '0;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_FETCH) ir <= ins;
      if (ret_inc) retired <= retired + CNT_W'(1);
      if (cur == S_DECODE && dec_ill) illegal <= 1'b1;
    end
  end

  always_comb begin
    nxt        = cur;
    pc_wr      = 1'b0;
    npc_sel    = NPC_PC4;
    ir_wr      = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    ext_op     = EXT_ZERO;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    ret_inc    = 1'b0;
    hold_alu   = 1'b0;
    unique case (cur)
      S_FETCH: begin
        // state is already FETCH while reset is low; keep ir_wr quiet then
        ir_wr = reset;
        nxt   = S_DECODE;
      end
      S_DECODE: begin
        unique case (cls)
          C_BEQ:   nxt = S_BR;
          C_J:     nxt = S_JMP;
          C_ILL: begin
            nxt   = S_FETCH;
            pc_wr = 1'b1;
          end
          default: nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        hold_alu = 1'b1;
        if (cls == C_LW)      nxt = S_MEM_RD;
        else if (cls == C_SW) nxt = S_MEM_WR;
        else                  nxt = S_WB;
      end
      S_MEM_RD: begin
        hold_alu = 1'b1;
        nxt      = S_WB;
      end
      S_MEM_WR: begin
        hold_alu = 1'b1;
        mem_wr   = 1'b1;
        pc_wr    = 1'b1;
        ret_inc  = 1'b1;
        nxt      = S_FETCH;
      end
      S_WB: begin
        hold_alu   = 1'b1;
        reg_wr     = 1'b1;
        pc_wr      = 1'b1;
        reg_dst    = (cls == C_ADDU) || (cls == C_SUBU);
        mem_to_reg = (cls == C_LW);
        ret_inc    = 1'b1;
        nxt        = S_FETCH;
      end
      S_BR: begin
        alu_src = 1'b0;
        alu_op  = ALU_SUB;
        pc_wr   = 1'b1;
        npc_sel = zero ? NPC_BEQ : NPC_PC4;
        ret_inc = 1'b1;
        nxt     = S_FETCH;
      end
      S_JMP: begin
        pc_wr   = 1'b1;
        npc_sel = NPC_JMP;
        ret_inc = 1'b1;
        nxt     = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase

    if (hold_alu) begin
      unique case (cls)
        C_SUBU: alu_op = ALU_SUB;
        C_ORI: begin
          alu_src = 1'b1;
          ext_op  = EXT_ZERO;
          alu_op  = ALU_OR;
        end
        C_LUI: begin
          alu_src = 1'b1;
          ext_op  = EXT_HI16;
          alu_op  = ALU_LUI;
        end
        C_LW, C_SW: begin
          alu_src = 1'b1;
          ext_op  = EXT_SIGN;
          alu_op  = ALU_ADD;
        end
        default: alu_op = ALU_ADD;
      endcase
    end
  end

endmodule
